// File: rtl/regfile_read_arbiter_pkg.sv
// Register file geometry shared by the read arbiter and future write-port logic.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 64;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_arbiter_picker.sv
// Combinational round-robin picker: the first eligible index at or after rr_ptr wins.
module round_robin_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_grant
);

   int idx;

   // Scan from the farthest offset down to rr_ptr so the closest eligible index overwrites last.
   always_comb begin
      winner    = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (eligible[IDX_W'(idx)]) begin
            winner    = IDX_W'(idx);
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's two read ports among NUM_REQ requesters, one winner per cycle,
// with a single-entry response buffer per requester.
//
// Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i]; a response
// transfers in the cycle resp_valid[i] && resp_ready[i]. Requesters hold req_valid and
// rs1/rs2 stable until req_ready; resp_ready is ignored while resp_valid is low.
module regfile_read_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_rs1,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_rs2,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              resp_valid,
   input  logic [NUM_REQ-1:0]              resp_ready,
   output logic [NUM_REQ-1:0][DATA_W-1:0]  resp_data1,
   output logic [NUM_REQ-1:0][DATA_W-1:0]  resp_data2,
   output logic [ADDR_W-1:0]               readRegister1,
   output logic [ADDR_W-1:0]               readRegister2,
   input  logic [DATA_W-1:0]               readData1,
   input  logic [DATA_W-1:0]               readData2,
   output logic                            grant_valid,
   output logic [IDX_W-1:0]                grant_id,
   output logic [IDX_W-1:0]                dbg_rr_ptr
);

   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] eligible;
   logic [IDX_W-1:0]   winner;
   logic               any_grant;
   logic [IDX_W-1:0]   next_ptr;

   // A full buffer being drained this cycle may take a new grant; reset forces everything idle.
   always_comb begin
      eligible = '0;
      if (reset_n) eligible = req_valid & (~resp_valid | resp_ready);
   end

   round_robin_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .winner    (winner),
      .any_grant (any_grant)
   );

   // Grant decode and read-port steering; ports read index 0 when nobody wins.
   always_comb begin
      req_ready     = '0;
      grant_valid   = any_grant;
      grant_id      = '0;
      readRegister1 = '0;
      readRegister2 = '0;
      next_ptr      = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      if (any_grant) begin
         req_ready[winner] = 1'b1;
         grant_id          = winner;
         readRegister1     = req_rs1[winner];
         readRegister2     = req_rs2[winner];
      end
   end

   // Pointer advances past each winner; buffers capture on grant, otherwise clear on drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         resp_valid <= '0;
         resp_data1 <= '0;
         resp_data2 <= '0;
      end else begin
         if (any_grant) rr_ptr <= next_ptr;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               resp_data1[i] <= readData1;
               resp_data2[i] <= readData2;
               resp_valid[i] <= 1'b1;
            end else if (resp_valid[i] && resp_ready[i]) begin
               resp_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a register file model returning 0x1000 + index.
module tb_regfile_read_arbiter;

   localparam int N = 4;

   logic                clk;
   logic                reset_n;
   logic [N-1:0]        req_valid;
   logic [N-1:0][4:0]   req_rs1;
   logic [N-1:0][4:0]   req_rs2;
   logic [N-1:0]        req_ready;
   logic [N-1:0]        resp_valid;
   logic [N-1:0]        resp_ready;
   logic [N-1:0][63:0]  resp_data1;
   logic [N-1:0][63:0]  resp_data2;
   logic [4:0]          readRegister1;
   logic [4:0]          readRegister2;
   logic [63:0]         readData1;
   logic [63:0]         readData2;
   logic                grant_valid;
   logic [1:0]          grant_id;
   logic [1:0]          dbg_rr_ptr;

   int tests_run;
   int tests_failed;

   regfile_read_arbiter #(.NUM_REQ(N)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_rs1       (req_rs1),
      .req_rs2       (req_rs2),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data1    (resp_data1),
      .resp_data2    (resp_data2),
      .readRegister1 (readRegister1),
      .readRegister2 (readRegister2),
      .readData1     (readData1),
      .readData2     (readData2),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .dbg_rr_ptr    (dbg_rr_ptr)
   );

   // Register file model: combinational read.
   assign readData1 = 64'h1000 + {59'd0, readRegister1};
   assign readData2 = 64'h1000 + {59'd0, readRegister2};

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      req_valid  = '0;
      req_rs1    = '0;
      req_rs2    = '0;
      resp_ready = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clear_inputs();

      // Reset state.
      reset_n = 1'b0;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_grant_valid", 64'(grant_valid), 64'd0);
      check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Idle for 10 cycles: nothing granted, pointer stays at 0.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("idle_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
         check("idle_grant", 64'(grant_valid), 64'd0);
      end
      check("idle_rd1", 64'(readRegister1), 64'd0);
      check("idle_resp_valid", 64'(resp_valid), 64'd0);

      // Single requester 2 reading r5/r7.
      req_valid  = 4'b0100;
      req_rs1[2] = 5'd5;
      req_rs2[2] = 5'd7;
      resp_ready = 4'hF;
      #1;
      check("r2_req_ready", 64'(req_ready), 64'b0100);
      check("r2_rd1", 64'(readRegister1), 64'd5);
      check("r2_rd2", 64'(readRegister2), 64'd7);
      check("r2_grant_id", 64'(grant_id), 64'd2);
      @(posedge clk);
      #1;
      req_valid = '0;
      check("r2_resp_valid", 64'(resp_valid), 64'b0100);
      check("r2_data1", resp_data1[2], 64'h1005);
      check("r2_data2", resp_data2[2], 64'h1007);
      check("r2_rr_ptr", 64'(dbg_rr_ptr), 64'd3);
      @(posedge clk);
      #1;
      check("r2_drained", 64'(resp_valid), 64'd0);

      // All four continuously valid: strict rotation from 0.
      do_reset();
      req_valid  = 4'hF;
      resp_ready = 4'hF;
      for (int i = 0; i < N; i++) req_rs1[i] = 5'(8 + i);
      for (int c = 0; c < 6; c++) begin
         #1;
         check("rot_grant_valid", 64'(grant_valid), 64'd1);
         check("rot_grant_id", 64'(grant_id), 64'(c % 4));
         check("rot_req_ready", 64'(req_ready), 64'(1 << (c % 4)));
         @(negedge clk);
      end
      check("rot_data1_r3", resp_data1[3], 64'h100B);

      // Requester 0 stalls its response while requester 1 keeps winning.
      do_reset();
      req_valid  = 4'b0011;
      req_rs1[0] = 5'd3;
      req_rs1[1] = 5'd9;
      resp_ready = 4'b0010;
      #1;
      check("stall_first_grant", 64'(grant_id), 64'd0);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_grant_r1", 64'(grant_id), 64'd1);
         check("stall_valid0", 64'(resp_valid[0]), 64'd1);
         check("stall_data0", resp_data1[0], 64'h1003);
         @(negedge clk);
      end
      req_rs1[0]    = 5'd4;
      resp_ready[0] = 1'b1;
      #1;
      check("stall_regrant0", 64'(grant_id), 64'd0);
      check("stall_regrant_rdy", 64'(req_ready), 64'b0001);
      @(posedge clk);
      #1;
      check("stall_new_valid0", 64'(resp_valid[0]), 64'd1);
      check("stall_new_data0", resp_data1[0], 64'h1004);

      // Back-to-back grants to requester 3.
      do_reset();
      req_valid  = 4'b1000;
      req_rs1[3] = 5'd1;
      resp_ready = 4'hF;
      #1;
      check("b2b_grant", 64'(grant_id), 64'd3);
      @(posedge clk);
      #1;
      check("b2b_valid_a", 64'(resp_valid[3]), 64'd1);
      check("b2b_data_a", resp_data1[3], 64'h1001);
      req_rs1[3] = 5'd2;
      #1;
      check("b2b_regrant", 64'(req_ready), 64'b1000);
      @(posedge clk);
      #1;
      check("b2b_valid_b", 64'(resp_valid[3]), 64'd1);
      check("b2b_data_b", resp_data1[3], 64'h1002);
      req_valid = '0;
      @(posedge clk);
      #1;
      check("b2b_drained", 64'(resp_valid), 64'd0);

      // Asynchronous reset mid-cycle with buffers 1 and 3 full.
      do_reset();
      req_valid   = 4'b1010;
      req_rs1[1]  = 5'd31;
      req_rs1[3]  = 5'd6;
      resp_ready  = '0;
      @(negedge clk);
      @(negedge clk);
      check("mid_resp_valid", 64'(resp_valid), 64'b1010);
      check("mid_r31_pass", resp_data1[1], 64'h101F);
      req_valid = 4'hF;
      #1;
      check("mid_pre_ready", 64'(req_ready), 64'b0001);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(resp_valid), 64'd0);
      check("mid_rst_ready", 64'(req_ready), 64'd0);
      check("mid_rst_grant", 64'(grant_valid), 64'd0);
      check("mid_rst_rd1", 64'(readRegister1), 64'd0);
      check("mid_rst_data", resp_data1[1], 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("mid_post_grant", 64'(grant_id), 64'd0);
      check("mid_post_ready", 64'(req_ready), 64'b0001);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
